// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM sequence controller.
package lstm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] ADDR_X_PUSH  = 32'h0000_0000;
    localparam logic [31:0] ADDR_SEQ_LEN = 32'h0000_0004;
    localparam logic [31:0] ADDR_CTRL    = 32'h0000_0008;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_CLR    = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    localparam int unsigned STS_BUSY   = 3;
    localparam int unsigned STS_XOVF   = 4;
    localparam int unsigned STS_YUNEXP = 5;

    // Assemble the published status word from its fields.
    function automatic logic [31:0] make_status(
        input state_t      st,
        input logic        x_ovf,
        input logic        y_unexp,
        input logic [7:0]  x_cnt,
        input logic [15:0] done_cnt
    );
        logic [31:0] s;
        s             = '0;
        s[2:0]        = st;
        s[STS_BUSY]   = (st != ST_IDLE);
        s[STS_XOVF]   = x_ovf;
        s[STS_YUNEXP] = y_unexp;
        s[15:8]       = x_cnt;
        s[31:16]      = done_cnt;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; output reads as zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array, written on accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lstm_sequence_ctrl.sv
// Buffers x samples into the LSTM core, collects y results, publishes status.
module lstm_sequence_ctrl
    import lstm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned LAYERS      = 4,
    parameter int unsigned X_DEPTH     = 16,
    parameter int unsigned Y_DEPTH     = 16,
    parameter logic [31:0] Y_LAST_ADDR = 32'h100,
    parameter logic [31:0] STATUS_ADDR = 32'h104
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           reg_addr,
    input  logic [31:0]           reg_wdata,
    input  logic                  reg_wen,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic                  x_out_valid,
    input  logic                  lstm_ready,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic                  y_in_valid,
    output logic [LAYERS-1:0]     state_clear,
    output logic [DATA_WIDTH-1:0] state_data,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  y_out_valid,
    input  logic                  y_out_ready,
    output logic [31:0]           update_addr,
    output logic [31:0]           update_data,
    output logic                  update_valid,
    output logic                  irq
);
    localparam int unsigned XCW = $clog2(X_DEPTH) + 1;
    localparam int unsigned YCW = $clog2(Y_DEPTH) + 1;
    localparam int unsigned LIW = (LAYERS > 1) ? $clog2(LAYERS) : 1;

    state_t                state;
    logic [LIW-1:0]        clear_idx;
    logic [15:0]           seq_len;
    logic [15:0]           samples_done;
    logic                  irq_en;
    logic                  x_overflow;
    logic                  y_unexpected;
    logic [31:0]           last_pub;
    logic [31:0]           status;

    logic                  wr_x, wr_len, wr_ctrl;
    logic                  start_cmd, abort_cmd, clr_cmd;
    logic                  x_push, x_full, x_empty, feed_go;
    logic [XCW-1:0]        x_count;
    logic [DATA_WIDTH-1:0] x_dout;
    logic                  y_push, y_pop, y_full, y_empty;
    logic [YCW-1:0]        y_count;
    logic                  unused_bits;

    // Register write decode.
    assign wr_x      = reg_wen && (reg_addr == ADDR_X_PUSH);
    assign wr_len    = reg_wen && (reg_addr == ADDR_SEQ_LEN);
    assign wr_ctrl   = reg_wen && (reg_addr == ADDR_CTRL);
    assign abort_cmd = wr_ctrl && reg_wdata[CTRL_ABORT];
    assign start_cmd = wr_ctrl && reg_wdata[CTRL_START] && !reg_wdata[CTRL_ABORT];
    assign clr_cmd   = wr_ctrl && reg_wdata[CTRL_CLR];

    // Full is judged before any same-cycle pop, so a pop never frees the slot early.
    assign x_push  = wr_x && !x_full;
    assign feed_go = (state == ST_FEED) && !abort_cmd && !x_empty && lstm_ready && !y_full;
    assign y_push  = (state == ST_WAIT) && y_in_valid && !abort_cmd;
    assign y_pop   = y_out_valid && y_out_ready;

    assign y_out_valid = !y_empty;
    assign state_data  = '0;
    assign status      = make_status(state, x_overflow, y_unexpected, 8'(x_count), samples_done);
    assign unused_bits = ^{reg_wdata, y_count};

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(X_DEPTH)) u_x_fifo (
        .clk   (clk),
        .rst   (rst || abort_cmd),
        .push  (x_push),
        .pop   (feed_go),
        .din   (reg_wdata[DATA_WIDTH-1:0]),
        .dout  (x_dout),
        .full  (x_full),
        .empty (x_empty),
        .count (x_count)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(Y_DEPTH)) u_y_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (y_push),
        .pop   (y_pop),
        .din   (y_in),
        .dout  (y_out),
        .full  (y_full),
        .empty (y_empty),
        .count (y_count)
    );

    // Sequencer FSM, control registers, sticky flags and status publisher.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            clear_idx    <= '0;
            seq_len      <= '0;
            samples_done <= '0;
            irq_en       <= 1'b0;
            x_overflow   <= 1'b0;
            y_unexpected <= 1'b0;
            last_pub     <= '0;
            x_out        <= '0;
            x_out_valid  <= 1'b0;
            state_clear  <= '0;
            irq          <= 1'b0;
            update_addr  <= '0;
            update_data  <= '0;
            update_valid <= 1'b0;
        end else begin
            x_out_valid <= 1'b0;
            irq         <= 1'b0;

            if (wr_len)  seq_len <= reg_wdata[15:0];
            if (wr_ctrl) irq_en  <= reg_wdata[CTRL_IRQ_EN];

            if (clr_cmd) begin
                x_overflow   <= 1'b0;
                y_unexpected <= 1'b0;
            end
            if (wr_x && x_full) x_overflow <= 1'b1;
            if (y_in_valid && (state != ST_WAIT) && (state != ST_DRAIN)) y_unexpected <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start_cmd) begin
                        state        <= ST_CLEAR;
                        samples_done <= '0;
                        clear_idx    <= '0;
                        state_clear  <= LAYERS'(1);
                    end
                end
                ST_CLEAR: begin
                    if (abort_cmd) begin
                        state       <= ST_IDLE;
                        state_clear <= '0;
                    end else if (clear_idx == LIW'(LAYERS - 1)) begin
                        state       <= ST_FEED;
                        state_clear <= '0;
                    end else begin
                        clear_idx   <= clear_idx + 1'b1;
                        state_clear <= state_clear << 1;
                    end
                end
                ST_FEED: begin
                    if (abort_cmd) begin
                        state <= ST_IDLE;
                    end else if (feed_go) begin
                        x_out       <= x_dout;
                        x_out_valid <= 1'b1;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A result landing on the abort cycle is already drained.
                    if (abort_cmd) begin
                        state <= y_in_valid ? ST_IDLE : ST_DRAIN;
                    end else if (y_in_valid) begin
                        if (samples_done != 16'hFFFF) samples_done <= samples_done + 1'b1;
                        if ((seq_len != '0) && ({1'b0, samples_done} + 17'd1 == {1'b0, seq_len})) begin
                            state <= ST_DONE;
                            irq   <= irq_en;
                        end else begin
                            state <= ST_FEED;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (y_in_valid) state <= ST_IDLE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // y results win the update port; status changes wait for a free cycle.
            if (y_push) begin
                update_valid <= 1'b1;
                update_addr  <= Y_LAST_ADDR;
                update_data  <= 32'(y_in);
            end else if (status != last_pub) begin
                update_valid <= 1'b1;
                update_addr  <= STATUS_ADDR;
                update_data  <= status;
                last_pub     <= status;
            end else begin
                update_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lstm_sequence_ctrl.sv
// Directed bench for lstm_sequence_ctrl with a fixed-latency core model.
module tb_lstm_sequence_ctrl;

    localparam logic [31:0] A_XPUSH  = 32'h0;
    localparam logic [31:0] A_SEQLEN = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_YLAST  = 32'h100;
    localparam logic [31:0] A_STATUS = 32'h104;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg_addr, reg_wdata;
    logic        reg_wen;
    logic [15:0] x_out;
    logic        x_out_valid;
    logic        lstm_ready;
    logic [15:0] y_in;
    logic        y_in_valid;
    logic [3:0]  state_clear;
    logic [15:0] state_data;
    logic [15:0] y_out;
    logic        y_out_valid;
    logic        y_out_ready;
    logic [31:0] update_addr, update_data;
    logic        update_valid;
    logic        irq;

    logic        core_v = 1'b0;
    logic [15:0] core_d = '0;
    logic        man_v = 1'b0;
    logic [15:0] man_d = '0;
    int          pend = 0;
    logic [15:0] pend_val = '0;

    assign y_in_valid = core_v | man_v;
    assign y_in       = man_v ? man_d : core_d;

    lstm_sequence_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_wen      (reg_wen),
        .x_out        (x_out),
        .x_out_valid  (x_out_valid),
        .lstm_ready   (lstm_ready),
        .y_in         (y_in),
        .y_in_valid   (y_in_valid),
        .state_clear  (state_clear),
        .state_data   (state_data),
        .y_out        (y_out),
        .y_out_valid  (y_out_valid),
        .y_out_ready  (y_out_ready),
        .update_addr  (update_addr),
        .update_data  (update_data),
        .update_valid (update_valid),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bench-side observation state.
    int          cyc = 0;
    logic [3:0]  clears[$];
    logic [15:0] ys[$];
    logic [31:0] upd_a[$];
    logic [31:0] upd_d[$];
    int          upd_c[$];
    int          irq_cnt = 0;
    int          xv_cnt = 0;
    int          ylast_cnt = 0;
    logic [31:0] last_status = '0;
    bit          saw_drain = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_status;
    } vec_t;
    vec_t vecs[18];

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: one sample in flight, answers x+1 five cycles after x_out_valid.
    always @(negedge clk) begin
        core_v = 1'b0;
        if (pend > 1) begin
            pend = pend - 1;
        end else if (pend == 1) begin
            core_v = 1'b1;
            core_d = pend_val;
            pend   = 0;
        end
        if (x_out_valid) begin
            pend     = 5;
            pend_val = x_out + 16'd1;
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (state_clear != '0) clears.push_back(state_clear);
        if (irq) irq_cnt++;
        if (x_out_valid) xv_cnt++;
        if (y_out_valid && y_out_ready) ys.push_back(y_out);
        if (update_valid) begin
            upd_a.push_back(update_addr);
            upd_d.push_back(update_data);
            upd_c.push_back(cyc);
            if (update_addr == A_YLAST) ylast_cnt++;
            if (update_addr == A_STATUS) begin
                last_status = update_data;
                if (update_data[2:0] == 3'd4) saw_drain = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wen   = 1'b1;
        @(posedge clk);
        #1;
        reg_wen   = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
    endtask

    task automatic wait_xv(input int target, input int lim, input string nm);
        int n;
        n = 0;
        while (xv_cnt < target && n < lim) begin
            idle(1);
            n++;
        end
        chk(nm, 32'(xv_cnt >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_xv, base_y, base_yl, fi;
        bit found;

        for (int i = 0; i < 17; i++) begin
            vecs[i].addr       = A_XPUSH;
            vecs[i].data       = 32'(100 + i);
            vecs[i].exp_status = 32'h0003_0000 | (32'((i < 16) ? i + 1 : 16) << 8)
                               | ((i == 16) ? 32'h10 : 32'h0);
        end
        vecs[17].addr       = A_CTRL;
        vecs[17].data       = 32'h4;
        vecs[17].exp_status = 32'h0003_1000;

        rst = 1'b1; reg_addr = '0; reg_wdata = '0; reg_wen = 1'b0;
        lstm_ready = 1'b1; y_out_ready = 1'b1;
        idle(3);

        // Reset state.
        chk("rst_x", {15'd0, x_out_valid, x_out}, 32'd0);
        chk("rst_clear_irq", {27'd0, irq, state_clear}, 32'd0);
        chk("rst_y", {15'd0, y_out_valid, y_out}, 32'd0);
        chk("rst_upd", {31'd0, update_valid} | update_addr | update_data, 32'd0);
        chk("rst_state_data", 32'(state_data), 32'd0);
        rst = 1'b0;
        idle(2);

        // Three-sample sequence with irq.
        wr(A_XPUSH, 32'd1);
        wr(A_XPUSH, 32'd2);
        wr(A_XPUSH, 32'd3);
        wr(A_SEQLEN, 32'd3);
        wr(A_CTRL, 32'h9);
        for (int n = 0; n < 300 && irq_cnt == 0; n++) idle(1);
        idle(6);
        chk("t1_clear_n", 32'(clears.size()), 32'd4);
        chk("t1_clear0", 32'(clears[0]), 32'h1);
        chk("t1_clear1", 32'(clears[1]), 32'h2);
        chk("t1_clear2", 32'(clears[2]), 32'h4);
        chk("t1_clear3", 32'(clears[3]), 32'h8);
        chk("t1_y_n", 32'(ys.size()), 32'd3);
        chk("t1_y0", 32'(ys[0]), 32'd2);
        chk("t1_y1", 32'(ys[1]), 32'd3);
        chk("t1_y2", 32'(ys[2]), 32'd4);
        chk("t1_irq", 32'(irq_cnt), 32'd1);
        chk("t1_xv", 32'(xv_cnt), 32'd3);
        chk("t1_status", last_status, 32'h0003_0000);
        chk("t1_ylast_n", 32'(ylast_cnt), 32'd3);

        // Status write after the first y write lands exactly one cycle later.
        found = 1'b0;
        fi = 0;
        for (int i = 0; i < upd_a.size() && !found; i++) begin
            if (upd_a[i] == A_YLAST) begin
                found = 1'b1;
                fi = i;
            end
        end
        chk("defer_found", 32'(found), 32'd1);
        if (found && fi + 1 < upd_a.size()) begin
            chk("defer_ylast_data", upd_d[fi], 32'd2);
            chk("defer_addr", upd_a[fi+1], A_STATUS);
            chk("defer_cycle", 32'(upd_c[fi+1] - upd_c[fi]), 32'd1);
            chk("defer_data", upd_d[fi+1], 32'h0001_020A);
        end else begin
            chk("defer_next_present", 32'(fi + 1 < upd_a.size()), 32'd1);
        end

        // Table: 17 pushes into a 16-deep FIFO, then clear the sticky flags.
        foreach (vecs[i]) begin
            wr(vecs[i].addr, vecs[i].data);
            idle(4);
            chk($sformatf("tbl%0d", i), last_status, vecs[i].exp_status);
        end

        // Output backpressure in continuous mode.
        y_out_ready = 1'b0;
        base_xv = xv_cnt;
        base_y  = ys.size();
        wr(A_SEQLEN, 32'd0);
        wr(A_CTRL, 32'h1);
        wait_xv(base_xv + 4, 300, "t3_first4");
        for (int i = 0; i < 4; i++) wr(A_XPUSH, 32'(116 + i));
        wait_xv(base_xv + 16, 600, "t3_first16");
        idle(40);
        chk("t3_xv16", 32'(xv_cnt - base_xv), 32'd16);
        chk("t3_status", last_status, 32'h0010_040A);
        chk("t3_head", {15'd0, y_out_valid, y_out}, {15'd0, 1'b1, 16'd101});
        y_out_ready = 1'b1;
        for (int n = 0; n < 600 && ys.size() < base_y + 20; n++) idle(1);
        idle(2);
        chk("t3_y_n", 32'(ys.size() - base_y), 32'd20);
        for (int i = 0; i < 20; i++) chk($sformatf("t3_y%0d", i), 32'(ys[base_y+i]), 32'(101 + i));
        chk("t3_xv20", 32'(xv_cnt - base_xv), 32'd20);

        // Abort while a sample is in flight.
        y_out_ready = 1'b0;
        base_xv = xv_cnt;
        base_y  = ys.size();
        base_yl = ylast_cnt;
        wr(A_XPUSH, 32'd200);
        wr(A_XPUSH, 32'd201);
        wr(A_XPUSH, 32'd202);
        wait_xv(base_xv + 2, 100, "t4_second_feed");
        wr(A_CTRL, 32'h2);
        idle(20);
        chk("t4_drain_seen", 32'(saw_drain), 32'd1);
        chk("t4_status", last_status, 32'h0015_0000);
        chk("t4_ylast_n", 32'(ylast_cnt - base_yl), 32'd1);
        chk("t4_xv", 32'(xv_cnt - base_xv), 32'd2);
        chk("t4_head", {15'd0, y_out_valid, y_out}, {15'd0, 1'b1, 16'd201});
        y_out_ready = 1'b1;
        idle(5);
        chk("t4_pop_n", 32'(ys.size() - base_y), 32'd1);
        chk("t4_pop_val", 32'(ys[base_y]), 32'd201);
        chk("t4_empty", 32'(y_out_valid), 32'd0);

        // Unexpected result in IDLE.
        base_yl = ylast_cnt;
        man_d = 16'h0055;
        man_v = 1'b1;
        idle(1);
        man_v = 1'b0;
        idle(5);
        chk("t5_status", last_status, 32'h0015_0020);
        chk("t5_no_ylast", 32'(ylast_cnt - base_yl), 32'd0);
        chk("t5_no_push", 32'(y_out_valid), 32'd0);
        wr(A_CTRL, 32'h4);
        idle(4);
        chk("t5_cleared", last_status, 32'h0015_0000);

        // Reset during FEED with queued samples.
        lstm_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(A_XPUSH, 32'(300 + i));
        wr(A_SEQLEN, 32'd7);
        wr(A_CTRL, 32'h9);
        idle(10);
        chk("t6_pre", last_status, 32'h0000_050A);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t6_x", {15'd0, x_out_valid, x_out}, 32'd0);
        chk("t6_clear_irq", {27'd0, irq, state_clear}, 32'd0);
        chk("t6_y", {15'd0, y_out_valid, y_out}, 32'd0);
        chk("t6_upd", {31'd0, update_valid} | update_addr | update_data, 32'd0);
        lstm_ready = 1'b1;
        wr(A_CTRL, 32'h1);
        idle(15);
        chk("t6_post", last_status, 32'h0000_000A);
        chk("t6_no_feed", 32'(pend), 32'd0);

        wr(A_CTRL, 32'h2);
        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
